sprite_layer_compositor: RTL

- Parametrised successor to the scene pixel generator.
- Composites NUM_LAYERS independently placed, integer-scaled 1-bit bitmap layers, each from its own ROM, over a background colour, with the mouse cursor on top.
- Replaces per-pixel divide/modulo addressing with incremental raster counters.
- Delays the pixel stream so ROM read latency is aligned, producing registered VGA colour at a fixed 2-pixel latency.
- Sits between vga_controller/mouse logic and the VGA pins; the scene FSM drives the layer descriptors.

---
 rtl/sprite_layer_compositor.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_layer_compositor.sv
// Composites NUM_LAYERS scaled 1-bit bitmap layers over a background,
// with the mouse cursor on top; registered colour at 2-strobe latency.
module sprite_layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 11,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_pix_en,
    input  logic [9:0]                   i_h_cnt,
    input  logic [9:0]                   i_v_cnt,
    input  logic                         i_valid,
    input  logic                         i_enable_mouse_display,
    input  logic [11:0]                  i_mouse_pixel,
    input  logic [11:0]                  i_bg_color,
    input  logic [NUM_LAYERS-1:0]        i_layer_en,
    input  logic [NUM_LAYERS*10-1:0]     i_layer_x,
    input  logic [NUM_LAYERS*10-1:0]     i_layer_y,
    input  logic [NUM_LAYERS*8-1:0]      i_layer_w,
    input  logic [NUM_LAYERS*8-1:0]      i_layer_h,
    input  logic [NUM_LAYERS*4-1:0]      i_layer_scale,
    input  logic [NUM_LAYERS*ADDR_W-1:0] i_layer_base,
    input  logic [NUM_LAYERS*12-1:0]     i_layer_fg,
    input  logic [NUM_LAYERS-1:0]        i_layer_opaque,
    input  logic [NUM_LAYERS*12-1:0]     i_layer_bg,
    output logic [NUM_LAYERS*ADDR_W-1:0] o_rom_addr,
    input  logic [NUM_LAYERS-1:0]        i_rom_data,
    output logic [3:0]                   o_vgaRed,
    output logic [3:0]                   o_vgaGreen,
    output logic [3:0]                   o_vgaBlue
);

    localparam logic [9:0] LP_H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] LP_V_END  = 10'(V_ACTIVE);

    logic                  w_frame_start;
    logic [NUM_LAYERS-1:0] w_inbox_vec;

    assign w_frame_start = (i_v_cnt == 10'd0) && (i_h_cnt == 10'd0);

    genvar g;
    for (g = 0; g < NUM_LAYERS; g++) begin : g_layer
        logic [9:0]        w_x;
        logic [9:0]        w_y;
        logic [7:0]        w_w;
        logic [7:0]        w_h;
        logic [3:0]        w_s;
        logic [ADDR_W-1:0] w_base;
        logic [11:0]       w_wspan;
        logic [11:0]       w_hspan;
        logic [12:0]       w_xend;
        logic [12:0]       w_yend;
        logic              w_hin;
        logic              w_vin;
        logic              w_inbox;
        logic              w_line_end;
        logic [3:0]        w_sub_x_cur;
        logic [7:0]        w_col_cur;
        logic [3:0]        w_sub_y_cur;
        logic [ADDR_W-1:0] w_row_cur;
        logic [3:0]        r_sub_x;
        logic [7:0]        r_col;
        logic [3:0]        r_sub_y;
        logic [ADDR_W-1:0] r_row;
        logic [ADDR_W-1:0] r_addr;

        assign w_x    = i_layer_x[g*10 +: 10];
        assign w_y    = i_layer_y[g*10 +: 10];
        assign w_w    = i_layer_w[g*8 +: 8];
        assign w_h    = i_layer_h[g*8 +: 8];
        assign w_base = i_layer_base[g*ADDR_W +: ADDR_W];
        assign w_s    = (i_layer_scale[g*4 +: 4] == 4'd0) ?
                        4'd1 : i_layer_scale[g*4 +: 4];

        // spans kept wide enough that x + w*scale never wraps
        assign w_wspan = {4'd0, w_w} * {8'd0, w_s};
        assign w_hspan = {4'd0, w_h} * {8'd0, w_s};
        assign w_xend  = {3'd0, w_x} + {1'b0, w_wspan};
        assign w_yend  = {3'd0, w_y} + {1'b0, w_hspan};

        assign w_hin   = (i_h_cnt >= w_x) && ({3'd0, i_h_cnt} < w_xend);
        assign w_vin   = (i_v_cnt >= w_y) && ({3'd0, i_v_cnt} < w_yend);
        assign w_inbox = i_layer_en[g] & w_hin & w_vin;

        assign w_line_end = (i_h_cnt == LP_H_LAST) && w_vin &&
                            (i_v_cnt < LP_V_END);

        assign w_sub_x_cur = (i_h_cnt == w_x) ? 4'd0 : r_sub_x;
        assign w_col_cur   = (i_h_cnt == w_x) ? 8'd0 : r_col;
        assign w_sub_y_cur = w_frame_start ? 4'd0 : r_sub_y;
        assign w_row_cur   = w_frame_start ? '0 : r_row;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_sub_x <= 4'd0;
                r_col   <= 8'd0;
                r_sub_y <= 4'd0;
                r_row   <= '0;
                r_addr  <= '0;
            end else if (i_pix_en) begin
                if (w_inbox && (w_sub_x_cur == w_s - 4'd1)) begin
                    r_sub_x <= 4'd0;
                    r_col   <= w_col_cur + 8'd1;
                end else if (w_inbox) begin
                    r_sub_x <= w_sub_x_cur + 4'd1;
                    r_col   <= w_col_cur;
                end else begin
                    r_sub_x <= w_sub_x_cur;
                    r_col   <= w_col_cur;
                end

                if (w_line_end && (w_sub_y_cur == w_s - 4'd1)) begin
                    r_sub_y <= 4'd0;
                    r_row   <= w_row_cur + ADDR_W'(w_w);
                end else if (w_line_end) begin
                    r_sub_y <= w_sub_y_cur + 4'd1;
                    r_row   <= w_row_cur;
                end else begin
                    r_sub_y <= w_sub_y_cur;
                    r_row   <= w_row_cur;
                end

                r_addr <= w_base + w_row_cur + ADDR_W'(w_col_cur);
            end
        end

        assign o_rom_addr[g*ADDR_W +: ADDR_W] = r_addr;
        assign w_inbox_vec[g] = w_inbox;
    end

    logic [NUM_LAYERS-1:0] r_box0;
    logic                  r_valid0;
    logic                  r_mouse0;
    logic [11:0]           r_mpix0;
    logic [NUM_LAYERS-1:0] r_box1;
    logic [NUM_LAYERS-1:0] r_bit1;
    logic                  r_valid1;
    logic                  r_mouse1;
    logic [11:0]           r_mpix1;
    logic [11:0]           r_rgb;
    logic [11:0]           w_color;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_box0   <= '0;
            r_valid0 <= 1'b0;
            r_mouse0 <= 1'b0;
            r_mpix0  <= 12'h000;
            r_box1   <= '0;
            r_bit1   <= '0;
            r_valid1 <= 1'b0;
            r_mouse1 <= 1'b0;
            r_mpix1  <= 12'h000;
            r_rgb    <= 12'h000;
        end else if (i_pix_en) begin
            r_box0   <= w_inbox_vec;
            r_valid0 <= i_valid;
            r_mouse0 <= i_enable_mouse_display;
            r_mpix0  <= i_mouse_pixel;
            r_box1   <= r_box0;
            r_bit1   <= i_rom_data;
            r_valid1 <= r_valid0;
            r_mouse1 <= r_mouse0;
            r_mpix1  <= r_mpix0;
            r_rgb    <= w_color;
        end
    end

    // descending scan so the lowest-index visible layer wins
    always_comb begin
        w_color = i_bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_box1[i] && (r_bit1[i] || i_layer_opaque[i])) begin
                w_color = r_bit1[i] ? i_layer_fg[i*12 +: 12]
                                    : i_layer_bg[i*12 +: 12];
            end
        end
        if (r_mouse1) w_color = r_mpix1;
        if (!r_valid1) w_color = 12'h000;
    end

    assign o_vgaRed   = r_rgb[11:8];
    assign o_vgaGreen = r_rgb[7:4];
    assign o_vgaBlue  = r_rgb[3:0];

endmodule
